// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pkg                                                   |
// | Purpose  : Shared definitions for the 1-bit-operand ALU and its      |
// |            result checker: default widths, opcode constants and the  |
// |            checker FSM state encoding.                               |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package alu_pkg;

  // Default widths shared by the ALU, the reference model and the checker.
  localparam int A_W_DEF   = 1;
  localparam int OP_W_DEF  = 3;
  localparam int OUT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Opcode map. The ALU decodes and the checker recomputes from the same
  // constants, so the two can never disagree on the encoding.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // Checker session state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } chk_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_ref_model                                             |
// | Purpose  : Purely combinational golden model of the ALU. Maps the    |
// |            operands and opcode to the expected ALU result. Usable    |
// |            inside the checker or stand-alone in a bench.             |
// | Ports    : i_a   [A_W]   operand a                                   |
// |            i_b   [A_W]   operand b                                   |
// |            i_op  [OP_W]  opcode                                      |
// |            o_exp [OUT_W] expected result (mod 2^OUT_W)               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [A_W-1:0]   i_a,
  input  logic [A_W-1:0]   i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [OUT_W-1:0] o_exp
);

  // Operands zero-extended to the result width; every arithmetic result
  // below is therefore naturally taken mod 2^OUT_W.
  logic [OUT_W-1:0] w_a_ext;
  logic [OUT_W-1:0] w_b_ext;

  // NAND/NOR are formed at operand width first and only then extended, so
  // the upper result bits stay zero instead of becoming inverted ones.
  logic [A_W-1:0] w_nand;
  logic [A_W-1:0] w_nor;

  assign w_a_ext = OUT_W'(i_a);
  assign w_b_ext = OUT_W'(i_b);
  assign w_nand  = ~(i_a & i_b);
  assign w_nor   = ~(i_a | i_b);

  always_comb begin
    o_exp = '0;
    case (i_op)
      OP_W'(OP_AND):  o_exp = w_a_ext & w_b_ext;
      OP_W'(OP_OR):   o_exp = w_a_ext | w_b_ext;
      OP_W'(OP_XOR):  o_exp = w_a_ext ^ w_b_ext;
      OP_W'(OP_ADD):  o_exp = w_a_ext + w_b_ext;
      // Two's-complement wrap: 0 - 1 yields all ones at OUT_W bits.
      OP_W'(OP_SUB):  o_exp = w_a_ext - w_b_ext;
      OP_W'(OP_NAND): o_exp = OUT_W'(w_nand);
      OP_W'(OP_NOR):  o_exp = OUT_W'(w_nor);
      OP_W'(OP_MUL):  o_exp = w_a_ext * w_b_ext;
      default:        o_exp = '0;
    endcase
  end

endmodule : alu_ref_model
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_result_checker                                        |
// | Purpose  : Self-checking monitor for the ALU output. Within a session |
// |            (start..stop) every qualified sample is compared against  |
// |            the reference model; saturating pass/fail counts are kept |
// |            and the first mismatch is captured for later inspection.  |
// | Ports    : clk      rising-edge clock                                |
// |            rst_n    synchronous active-low reset                     |
// |            start    pulse: begin (or restart) a session, clears all  |
// |            stop     pulse: end the session, enter REPORT             |
// |            vld      a/b/op/dut_out valid this cycle                  |
// |            a, b     operands applied to the ALU                      |
// |            op       opcode applied to the ALU                        |
// |            dut_out  ALU result for a/b/op                            |
// |            pass_cnt matching samples (saturating)                    |
// |            fail_cnt mismatching samples (saturating)                 |
// |            err      sticky first-mismatch flag                       |
// |            ff_op/ff_exp/ff_got  first failing sample                 |
// |            busy     high in RUN                                      |
// |            done     high in REPORT                                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             vld,
  input  logic [A_W-1:0]   a,
  input  logic [A_W-1:0]   b,
  input  logic [OP_W-1:0]  op,
  input  logic [OUT_W-1:0] dut_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [OP_W-1:0]  ff_op,
  output logic [OUT_W-1:0] ff_exp,
  output logic [OUT_W-1:0] ff_got,
  output logic             busy,
  output logic             done
);

  // --------------------------------------------------------------------
  // Reference model: expected value for the sample on the inputs now.
  // --------------------------------------------------------------------
  logic [OUT_W-1:0] w_exp;
  logic             w_match;

  alu_ref_model #(
    .A_W   (A_W),
    .OP_W  (OP_W),
    .OUT_W (OUT_W)
  ) u_ref (
    .i_a   (a),
    .i_b   (b),
    .i_op  (op),
    .o_exp (w_exp)
  );

  assign w_match = (w_exp == dut_out);

  // --------------------------------------------------------------------
  // Session FSM
  // --------------------------------------------------------------------
  chk_state_t r_state;
  chk_state_t w_state_nxt;
  logic       w_clear;   // wipe counts / err / first-fail capture
  logic       w_sample;  // compare the current sample this edge

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start has priority over everything: it opens a fresh session from any
  // state, and a sample arriving with it belongs to no session, so it is
  // dropped. A sample arriving with stop still belongs to the session.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_sample    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (start) begin
          w_clear = 1'b1;
        end else begin
          w_sample = vld;
          if (stop) begin
            w_state_nxt = REPORT;
          end
        end
      end
      REPORT: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = RUN;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err;
  logic [OP_W-1:0]  r_ff_op;
  logic [OUT_W-1:0] r_ff_exp;
  logic [OUT_W-1:0] r_ff_got;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_op    <= '0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
    end else if (w_clear) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_op    <= '0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
    end else if (w_sample) begin
      if (w_match) begin
        // Saturate at all-ones rather than wrapping back to zero.
        if (r_pass_cnt != '1) begin
          r_pass_cnt <= r_pass_cnt + CNT_W'(1);
        end
      end else begin
        if (r_fail_cnt != '1) begin
          r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        end
        // Only the first mismatch of a session is captured; err gates
        // every later load so the snapshot stays stable.
        if (!r_err) begin
          r_ff_op  <= op;
          r_ff_exp <= w_exp;
          r_ff_got <= dut_out;
        end
        r_err <= 1'b1;
      end
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  assign err      = r_err;
  assign ff_op    = r_ff_op;
  assign ff_exp   = r_ff_exp;
  assign ff_got   = r_ff_got;

endmodule : alu_result_checker
`default_nettype wire

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Synthesizable self-checking monitor on the output side of the 1-bit-operand ALU.
- Samples each applied operand/opcode set together with the ALU result and recomputes the expected result with an internal reference model.
- Keeps saturating pass/fail counts and captures the first mismatch, so the ALU can be checked in simulation or on FPGA without a waveform viewer.

Parameters:
- A_W, 1, operand width of a and b.
- OP_W, 3, opcode width.
- OUT_W, 4, ALU result width.
- CNT_W, 8, width of the pass and fail counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  1-cycle pulse that begins a check session.
- stop  in  1  1-cycle pulse that ends the session.
- vld  in  1  sample qualifier; a, b, op and dut_out are valid this cycle.
- a  in  A_W  operand a applied to the ALU.
- b  in  A_W  operand b applied to the ALU.
- op  in  OP_W  opcode applied to the ALU.
- dut_out  in  OUT_W  ALU result for that a/b/op.
- pass_cnt  out  CNT_W  number of matching samples.
- fail_cnt  out  CNT_W  number of mismatching samples.
- err  out  1  sticky; set on the first mismatch of the session.
- ff_op  out  OP_W  opcode of the first failing sample.
- ff_exp  out  OUT_W  expected value of the first failing sample.
- ff_got  out  OUT_W  dut_out of the first failing sample.
- busy  out  1  high in RUN.
- done  out  1  high in REPORT.

Behaviour:
- Reset: clock is clk; reset rst_n is synchronous and active-low. While rst_n=0 at a clk edge: state=IDLE and every output is 0.
- Reference model: operands are zero-extended to OUT_W, and results are taken mod 2^OUT_W.
  - 000 AND, 001 OR, 010 XOR
  - 011 ADD a+b
  - 100 SUB a-b (two's-complement wrap)
  - 101 NAND, 110 NOR: computed at A_W bits, then zero-extended
  - 111 MUL a*b
- FSM:
  - IDLE -> RUN on start. On that edge pass_cnt, fail_cnt, err and the ff_* registers clear to 0.
  - RUN -> REPORT on stop.
  - REPORT -> RUN on start, with the same clear.
  - stop in IDLE or REPORT is ignored. start in RUN restarts the session: clear and stay in RUN.
- Compare:
  - Only in RUN, only when vld=1.
  - Expected value is computed combinationally from a, b and op in the same cycle. The counter/err/ff_* update is registered: visible 1 cycle after the vld edge.
  - vld outside RUN is ignored.
- Saturation: pass_cnt and fail_cnt stop at 2^CNT_W-1 and never wrap.
- First-fail capture: ff_op, ff_exp and ff_got load only when err=0 and a mismatch is sampled; err is set on the same edge. Later mismatches only increment fail_cnt.
- Simultaneous events:
  - vld together with stop in RUN: the sample is still checked and the FSM enters REPORT on the same edge, so done rises with the final counts.
  - vld together with start: the clear wins and the sample is discarded.
- Mid-session reset (rst_n low during RUN): everything returns to its reset value; no partial results are kept.
- Output stability: counts and ff_* are held stable in REPORT until the next start.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants OP_AND … OP_MUL (3'b000–3'b111),
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, REPORT=2'd2),
  - the default widths.
- The ALU itself and this checker both use the same opcode constants.
- One sub-module: alu_ref_model, purely combinational, mapping a, b, op to the expected result. It is reusable as a golden model in benches.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, vld pulses while in IDLE -> all outputs 0, busy=0, done=0.
- All-pass sweep: start, then 8 vld samples with correct dut_out, including a=1,b=0,op=100 -> 0001 and a=1,b=1,op=011 -> 0010, then stop -> pass_cnt=8, fail_cnt=0, err=0, done=1.
- SUB wrap: a=0,b=1,op=100, dut_out=0001 -> fail_cnt=1, err=1, ff_op=100, ff_exp=1111, ff_got=0001.
- First-fail hold: a mismatch on NAND a=0,b=0 (exp 0001, got 0000), then a mismatch on NOR -> fail_cnt=2, ff_op stays 101, ff_exp=0001.
- Saturation: CNT_W=2, 5 passing samples -> pass_cnt=3.
- Edge collisions:
  - vld with stop -> sample counted and done=1 next cycle.
  - vld with start in RUN -> counters=0 and the sample is not counted.
